// File: rtl/svo_hdmi_period_ctl.sv
// rtl/svo_hdmi_period_ctl.sv - HDMI preamble/guard-band sequencer with lookahead delay line
//
// Purpose: delays the pixel stream by LEAD = PREAMBLE_LEN+GUARD_LEN cycles plus one output
// register. The lookahead lets the sequencer insert the video preamble and the video guard band
// immediately ahead of each active-video run. Blanking gaps too short to hold the sequence are
// flagged, and that run passes through without preamble or guard (plain DVI).
//
// Ports:
//   clk             pixel clock, all logic on posedge
//   reset           synchronous, active-high
//   in_de           active video
//   in_hsync        horizontal sync
//   in_vsync        vertical sync
//   in_rgb          pixel {R,G,B}
//   out_de          delayed in_de, forced low during preamble/guard
//   out_ctrl0       delayed {vsync,hsync}
//   out_ctrl1       {CTL1,CTL0}, 01 during preamble
//   out_ctrl2       {CTL3,CTL2}, always 00 for video preamble
//   out_guard       encoders emit video guard band code this cycle
//   out_rgb         delayed in_rgb
//   err_short_blank one-cycle pulse on a DE rise that cannot get a preamble
module svo_hdmi_period_ctl #(
  parameter int PREAMBLE_LEN   = 8,
  parameter int GUARD_LEN      = 2,
  parameter int MIN_CTRL_LEN   = 4,
  parameter bit DVI_MODE       = 1'b0,
  parameter int BITS_PER_PIXEL = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_de,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  logic [BITS_PER_PIXEL-1:0] in_rgb,
  output logic                      out_de,
  output logic [1:0]                out_ctrl0,
  output logic [1:0]                out_ctrl1,
  output logic [1:0]                out_ctrl2,
  output logic                      out_guard,
  output logic [BITS_PER_PIXEL-1:0] out_rgb,
  output logic                      err_short_blank
);

  localparam int LEAD    = PREAMBLE_LEN + GUARD_LEN;
  localparam int GAP_MAX = LEAD + MIN_CTRL_LEN;
  localparam int CW      = $clog2(GAP_MAX + 1);
  localparam int DW      = BITS_PER_PIXEL + 3;

  typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GUARD, ST_VIDEO} state_t;

  // Delay line word: {de, vsync, hsync, rgb}
  logic [DW-1:0] dl [LEAD];
  logic          prev_de;
  logic [CW-1:0] gap_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          rise, qual, tail_de;
  logic          de_d, guard_d, err_d;
  logic [1:0]    ctrl1_d;

  assign tail_de = dl[LEAD-1][DW-1];
  assign rise    = in_de & ~prev_de;
  // gap_q counts the blanking cycles strictly before this rise
  assign qual    = rise && (gap_q >= CW'(GAP_MAX)) && (state_q == ST_CTRL) && !DVI_MODE;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEAD; i++) dl[i] <= '0;
      prev_de <= 1'b0;
      gap_q   <= '0;
    end else begin
      dl[0] <= {in_de, in_vsync, in_hsync, in_rgb};
      for (int i = 1; i < LEAD; i++) dl[i] <= dl[i-1];
      prev_de <= in_de;
      if (in_de)
        gap_q <= '0;
      else if (gap_q < CW'(GAP_MAX))
        gap_q <= gap_q + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CTRL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CTRL: begin
        if (qual) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == CW'(GUARD_LEN - 1)) begin
          state_d = ST_VIDEO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_VIDEO: begin
        // Leave once the pixel about to be output is blanking
        if (!tail_de) state_d = ST_CTRL;
      end
      default: state_d = ST_CTRL;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    ctrl1_d = (state_d == ST_PRE) ? 2'b01 : 2'b00;
    guard_d = (state_d == ST_GUARD);
    de_d    = tail_de && (state_d != ST_PRE) && (state_d != ST_GUARD);
    err_d   = rise && !qual && !DVI_MODE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_de          <= 1'b0;
      out_ctrl0       <= 2'b00;
      out_ctrl1       <= 2'b00;
      out_ctrl2       <= 2'b00;
      out_guard       <= 1'b0;
      out_rgb         <= '0;
      err_short_blank <= 1'b0;
    end else begin
      out_de          <= de_d;
      out_ctrl0       <= dl[LEAD-1][BITS_PER_PIXEL+1:BITS_PER_PIXEL];
      out_ctrl1       <= ctrl1_d;
      out_ctrl2       <= 2'b00;
      out_guard       <= guard_d;
      out_rgb         <= dl[LEAD-1][BITS_PER_PIXEL-1:0];
      err_short_blank <= err_d;
    end
  end

endmodule

// File: tb/tb_svo_hdmi_period_ctl.sv
// tb/tb_svo_hdmi_period_ctl.sv - directed bench for svo_hdmi_period_ctl
module tb_svo_hdmi_period_ctl;

  localparam int LEAD = 10;

  logic        clk = 1'b0;
  logic        reset, in_de, in_hsync, in_vsync;
  logic [23:0] in_rgb;

  logic        a_de, a_g, a_err, b_de, b_g, b_err;
  logic [1:0]  a_c0, a_c1, a_c2, b_c0, b_c1, b_c2;
  logic [23:0] a_rgb, b_rgb;
  logic [32:0] obs_a, obs_b;

  assign obs_a = {a_de, a_c0, a_c1, a_c2, a_g, a_err, a_rgb};
  assign obs_b = {b_de, b_c0, b_c1, b_c2, b_g, b_err, b_rgb};

  svo_hdmi_period_ctl #(.DVI_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_rgb(in_rgb), .out_de(a_de), .out_ctrl0(a_c0), .out_ctrl1(a_c1), .out_ctrl2(a_c2),
    .out_guard(a_g), .out_rgb(a_rgb), .err_short_blank(a_err)
  );

  svo_hdmi_period_ctl #(.DVI_MODE(1'b1)) dut_dvi (
    .clk(clk), .reset(reset), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_rgb(in_rgb), .out_de(b_de), .out_ctrl0(b_c0), .out_ctrl1(b_c1), .out_ctrl2(b_c2),
    .out_guard(b_g), .out_rgb(b_rgb), .err_short_blank(b_err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          last_rst = -1000;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [26:0] hist [0:4095];

  task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                      input logic [23:0] rgb);
    reset = r; in_de = de; in_hsync = hs; in_vsync = vs; in_rgb = rgb;
    @(posedge clk); #1;
    cyc++;
    hist[cyc] = r ? 27'd0 : {de, vs, hs, rgb};
    if (r) last_rst = cyc;
  endtask

  // Input seen LEAD+1 edges ago ({de,vs,hs,rgb}); anything sampled at or before a reset edge is gone
  function automatic logic [26:0] dly(input int c);
    if (c - LEAD <= last_rst || c - LEAD < 1) return 27'd0;
    return hist[c - LEAD];
  endfunction

  task automatic test_reset;
    logic [26:0] d;
    logic [32:0] ex;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
      n_cmp++;
      if (obs_a !== 33'd0) begin n_bad++; $display("FAIL reset_a cyc=%0d got=%h exp=0", cyc, obs_a); end
      n_cmp++;
      if (obs_b !== 33'd0) begin n_bad++; $display("FAIL reset_b cyc=%0d got=%h exp=0", cyc, obs_b); end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom));
      d  = dly(cyc);
      ex = {d[26], d[25:24], 2'b00, 2'b00, 1'b0, 1'b0, d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL release_a cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
      n_cmp++;
      if (obs_b !== ex) begin n_bad++; $display("FAIL release_b cyc=%0d got=%h exp=%h", cyc, obs_b, ex); end
    end
  endtask

  task automatic test_preamble;
    int s, e;
    logic de;
    logic [26:0] d;
    logic [32:0] ex;
    s = cyc; e = s + 21;
    for (int i = 0; i < 66; i++) begin
      de = (i >= 20 && i < 36);
      step(1'b0, de, 1'b0, 1'b0, de ? 24'(i - 19) : 24'd0);
      d  = dly(cyc);
      ex = {d[26], d[25:24], (cyc >= e && cyc < e + 8) ? 2'b01 : 2'b00, 2'b00,
            (cyc >= e + 8 && cyc < e + 10), 1'b0, d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL preamble cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
    end
  endtask

  task automatic test_short_gap;
    int s, e1, e2;
    logic de;
    logic [26:0] d;
    logic [32:0] ex;
    s = cyc; e1 = s + 21; e2 = s + 38;
    for (int i = 0; i < 73; i++) begin
      de = (i >= 20 && i < 24) || (i >= 37 && i < 43);
      step(1'b0, de, 1'b0, 1'b0, de ? 24'(32'hA0 + i) : 24'd0);
      d  = dly(cyc);
      ex = {d[26], d[25:24], (cyc >= e1 && cyc < e1 + 8) ? 2'b01 : 2'b00, 2'b00,
            (cyc >= e1 + 8 && cyc < e1 + 10), (cyc == e2), d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL short_gap cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
    end
  endtask

  task automatic test_sync_passthrough;
    int s, e;
    logic de;
    logic [26:0] d;
    logic [32:0] ex;
    s = cyc; e = s + 21;
    for (int i = 0; i < 58; i++) begin
      de = (i >= 20 && i < 28);
      step(1'b0, de, 1'(i), 1'(i >> 2), de ? 24'(32'h5500 + i) : 24'(i));
      d  = dly(cyc);
      ex = {d[26], d[25:24], (cyc >= e && cyc < e + 8) ? 2'b01 : 2'b00, 2'b00,
            (cyc >= e + 8 && cyc < e + 10), 1'b0, d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL sync_pass cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
    end
  endtask

  task automatic test_reset_mid_preamble;
    int s, e, e2;
    logic de, r;
    logic [26:0] d;
    logic [32:0] ex;
    s = cyc; e = s + 21; e2 = s + 30;
    for (int i = 0; i < 63; i++) begin
      r  = (i == 23);
      de = (i >= 20 && i < 24) || (i >= 29 && i < 33);
      step(r, de, 1'b0, 1'b0, de ? 24'(32'h7700 + i) : 24'd0);
      d  = dly(cyc);
      ex = {d[26], d[25:24], (cyc >= e && cyc < e + 3) ? 2'b01 : 2'b00, 2'b00,
            1'b0, (cyc == e2), d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
    end
  endtask

  task automatic test_back_to_back;
    int s, e1, e2;
    logic de;
    logic [26:0] d;
    logic [32:0] ex;
    s = cyc; e1 = s + 21; e2 = s + 39;
    for (int i = 0; i < 72; i++) begin
      de = (i >= 20 && i < 24) || (i >= 38 && i < 42);
      step(1'b0, de, 1'b1, 1'b0, de ? 24'(32'hC000 + i) : 24'd0);
      d  = dly(cyc);
      ex = {d[26], d[25:24],
            ((cyc >= e1 && cyc < e1 + 8) || (cyc >= e2 && cyc < e2 + 8)) ? 2'b01 : 2'b00, 2'b00,
            ((cyc >= e1 + 8 && cyc < e1 + 10) || (cyc >= e2 + 8 && cyc < e2 + 10)), 1'b0, d[23:0]};
      n_cmp++;
      if (obs_a !== ex) begin n_bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_a, ex); end
    end
  endtask

  task automatic test_dvi_mode;
    logic de;
    logic [26:0] d;
    logic [32:0] ex;
    for (int i = 0; i < 66; i++) begin
      de = (i >= 20 && i < 36);
      step(1'b0, de, 1'b0, 1'b0, de ? 24'(i - 19) : 24'd0);
      d  = dly(cyc);
      ex = {d[26], d[25:24], 2'b00, 2'b00, 1'b0, 1'b0, d[23:0]};
      n_cmp++;
      if (obs_b !== ex) begin n_bad++; $display("FAIL dvi_mode cyc=%0d got=%h exp=%h", cyc, obs_b, ex); end
    end
  endtask

  initial begin
    reset = 1'b1; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_rgb = '0;
    test_reset;
    test_preamble;
    test_short_gap;
    test_sync_passthrough;
    test_reset_mid_preamble;
    test_back_to_back;
    test_dvi_mode;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
